// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The master side is the datapath (hazard sources); the slave side is the sequencer.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_valid;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic             ex_mc_start;
    logic             mc_done;
    logic             imem_ready;
    logic             pc_en;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_hold;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_is_load, ex_rd, ex_redirect, ex_mc_start,
        output mc_done, imem_ready,
        input  pc_en, if_id_stall, if_id_flush, id_ex_flush, ex_hold,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_is_load, ex_rd, ex_redirect, ex_mc_start,
        input  mc_done, imem_ready,
        output pc_en, if_id_stall, if_id_flush, id_ex_flush, ex_hold,
        output stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC enable and IF/ID, ID/EX stall/flush from redirect, multi-cycle, load-use, imem wait.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int FETCH_LAT = 1,
    parameter int CNT_W     = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave ctl
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        SQUASH  = 2'd2
    } state_t;

    localparam logic [1:0] SQ_RELOAD = 2'(FETCH_LAT - 1);

    state_t     state, state_nxt;
    logic [1:0] sq_cnt, sq_cnt_nxt;
    logic       load_use;
    logic       redirect_acc;
    logic       pc_en_c, if_id_stall_c, if_id_flush_c, id_ex_flush_c, ex_hold_c;

    assign load_use = ctl.ex_valid && ctl.ex_is_load && (ctl.ex_rd != 5'd0) && ctl.id_valid &&
                      ((ctl.id_uses_rs1 && (ctl.id_rs1 == ctl.ex_rd)) ||
                       (ctl.id_uses_rs2 && (ctl.id_rs2 == ctl.ex_rd)));

    always_comb begin
        pc_en_c       = 1'b0;
        if_id_stall_c = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        ex_hold_c     = 1'b0;
        redirect_acc  = 1'b0;
        state_nxt     = state;
        sq_cnt_nxt    = sq_cnt;
        case (state)
            RUN: begin
                if (ctl.ex_redirect) begin
                    pc_en_c       = 1'b1;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    redirect_acc  = 1'b1;
                    if (FETCH_LAT > 1) begin
                        state_nxt  = SQUASH;
                        sq_cnt_nxt = SQ_RELOAD;
                    end
                end else if (ctl.ex_mc_start && !ctl.mc_done) begin
                    if_id_stall_c = 1'b1;
                    ex_hold_c     = 1'b1;
                    state_nxt     = MC_WAIT;
                end else if (load_use) begin
                    // Holding IF/ID also covers a concurrent imem wait: the consumer must survive.
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (!ctl.imem_ready) begin
                    if_id_flush_c = 1'b1;
                end else begin
                    pc_en_c = 1'b1;
                end
            end
            MC_WAIT: begin
                if (ctl.mc_done) begin
                    pc_en_c   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    if_id_stall_c = 1'b1;
                    ex_hold_c     = 1'b1;
                end
            end
            SQUASH: begin
                if_id_flush_c = 1'b1;
                pc_en_c       = ctl.imem_ready;
                if (ctl.ex_redirect) begin
                    id_ex_flush_c = 1'b1;
                    redirect_acc  = 1'b1;
                    sq_cnt_nxt    = SQ_RELOAD;
                end else if (sq_cnt == 2'd1) begin
                    state_nxt  = RUN;
                    sq_cnt_nxt = '0;
                end else begin
                    sq_cnt_nxt = sq_cnt - 2'd1;
                end
            end
            default: begin
                state_nxt  = RUN;
                sq_cnt_nxt = '0;
            end
        endcase
        if (!rst) begin
            pc_en_c       = 1'b0;
            if_id_stall_c = 1'b0;
            if_id_flush_c = 1'b0;
            id_ex_flush_c = 1'b0;
            ex_hold_c     = 1'b0;
            redirect_acc  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            sq_cnt <= '0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_cnt_nxt;
        end
    end

    assign ctl.pc_en       = pc_en_c;
    assign ctl.if_id_stall = if_id_stall_c;
    assign ctl.if_id_flush = if_id_flush_c;
    assign ctl.id_ex_flush = id_ex_flush_c;
    assign ctl.ex_hold     = ex_hold_c;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Saturating counters: hold at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en_c && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (redirect_acc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign ctl.stall_cycles = stall_q;
    assign ctl.flush_count  = flush_q;
`else
    assign ctl.stall_cycles = '0;
    assign ctl.flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic against a reference model.
module tb_pipe_hazard_ctrl;
    localparam int FL = 3;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();
    pipe_hazard_ctrl #(.FETCH_LAT(FL), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .ctl(bus));

    int vectors = 0;
    int miscompares = 0;

    // Reference state: whether a multi-cycle op is outstanding, squash cycles left, event totals.
    bit          m_busy;
    int          m_sq_left;
    longint      m_stalls, m_flushes;
    bit          e_pc, e_stall, e_iff, e_ief, e_hold;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0; m_sq_left = 0; m_stalls = 0; m_flushes = 0;
    endfunction

    function automatic void model_outputs();
        bit lu;
        lu = bus.ex_valid && bus.ex_is_load && bus.ex_rd != 0 && bus.id_valid &&
             ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
        {e_pc, e_stall, e_iff, e_ief, e_hold} = '0;
        if (!rst) begin
            model_reset();
        end else if (m_busy) begin
            if (bus.mc_done) e_pc = 1; else begin e_stall = 1; e_hold = 1; end
        end else if (m_sq_left > 0) begin
            e_iff = 1; e_pc = bus.imem_ready; e_ief = bus.ex_redirect;
        end else if (bus.ex_redirect) begin
            e_pc = 1; e_iff = 1; e_ief = 1;
        end else if (bus.ex_mc_start && !bus.mc_done) begin
            e_stall = 1; e_hold = 1;
        end else if (lu) begin
            e_stall = 1; e_ief = 1;
        end else if (!bus.imem_ready) begin
            e_iff = 1;
        end else begin
            e_pc = 1;
        end
    endfunction

    function automatic void model_update();
        if (!rst) begin
            model_reset();
            return;
        end
        if (!e_pc && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        if (m_busy) begin
            if (bus.mc_done) m_busy = 0;
        end else if (bus.ex_redirect) begin
            if (m_flushes < 64'hFFFF_FFFF) m_flushes++;
            m_sq_left = FL - 1;
        end else if (m_sq_left > 0) begin
            m_sq_left--;
        end else if (bus.ex_mc_start && !bus.mc_done) begin
            m_busy = 1;
        end
    endfunction

    task automatic check();
        logic [31:0] e_sc, e_fc;
        model_outputs();
`ifdef PIPE_CTRL_PERF_EN
        e_sc = 32'(m_stalls); e_fc = 32'(m_flushes);
`else
        e_sc = '0; e_fc = '0;
`endif
        cmp("pc_en", 32'(bus.pc_en), 32'(e_pc));
        cmp("if_id_stall", 32'(bus.if_id_stall), 32'(e_stall));
        cmp("if_id_flush", 32'(bus.if_id_flush), 32'(e_iff));
        cmp("id_ex_flush", 32'(bus.id_ex_flush), 32'(e_ief));
        cmp("ex_hold", 32'(bus.ex_hold), 32'(e_hold));
        cmp("stall_cycles", bus.stall_cycles, e_sc);
        cmp("flush_count", bus.flush_count, e_fc);
        cmp("stall_flush_excl", 32'(bus.if_id_stall & bus.if_id_flush), 32'd0);
    endtask

    task automatic sample();
        @(negedge clk);
        check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle();
        bus.id_valid = 1; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
        bus.ex_valid = 0; bus.ex_is_load = 0; bus.ex_rd = 0; bus.ex_redirect = 0;
        bus.ex_mc_start = 0; bus.mc_done = 0; bus.imem_ready = 1;
    endtask

    task automatic load_use_on(input logic [4:0] rd);
        bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_rd = rd; bus.id_uses_rs1 = 1; bus.id_rs1 = rd;
    endtask

    initial begin
        model_reset();
        rst = 0;
        idle();
        #1;
        step();
        step();
        @(posedge clk); #1;
        rst = 1;

        // Load-use: one stall cycle, then clear; x0 destination never stalls.
        load_use_on(5'd5);
        sample();
        cmp("lu_pc", 32'(bus.pc_en), 0); cmp("lu_stall", 32'(bus.if_id_stall), 1);
        cmp("lu_ief", 32'(bus.id_ex_flush), 1);
        advance();
        idle();
        sample(); cmp("lu_after_pc", 32'(bus.pc_en), 1); advance();
        load_use_on(5'd0);
        sample(); cmp("lu_x0_stall", 32'(bus.if_id_stall), 0); advance();
        idle();

        // Multi-cycle: mc_done four cycles after start; redirect mid-wait ignored.
        bus.ex_mc_start = 1;
        sample(); cmp("mc_c1_hold", 32'(bus.ex_hold), 1); advance();
        bus.ex_mc_start = 0;
        step();
        bus.ex_redirect = 1;
        sample(); cmp("mc_redir_ign", 32'(bus.if_id_flush), 0); cmp("mc_c3_stall", 32'(bus.if_id_stall), 1);
        advance();
        bus.ex_redirect = 0;
        sample(); cmp("mc_c4_pc", 32'(bus.pc_en), 0); advance();
        bus.mc_done = 1;
        sample(); cmp("mc_rel_pc", 32'(bus.pc_en), 1); cmp("mc_rel_hold", 32'(bus.ex_hold), 0); advance();
        idle();
        sample(); cmp("mc_after_pc", 32'(bus.pc_en), 1); advance();

        // Redirect with FETCH_LAT=3: three flush cycles.
        bus.ex_redirect = 1;
        sample(); cmp("rd_c1_iff", 32'(bus.if_id_flush), 1); cmp("rd_c1_ief", 32'(bus.id_ex_flush), 1); advance();
        bus.ex_redirect = 0;
        sample(); cmp("rd_c2_ief", 32'(bus.id_ex_flush), 0); cmp("rd_c2_iff", 32'(bus.if_id_flush), 1); advance();
        sample(); cmp("rd_c3_iff", 32'(bus.if_id_flush), 1); advance();
        sample(); cmp("rd_c4_iff", 32'(bus.if_id_flush), 0); advance();

        // Second redirect in cycle 2 extends squash to cycle 4.
        bus.ex_redirect = 1;
        step();
        sample(); cmp("rd2_c2_ief", 32'(bus.id_ex_flush), 1); advance();
        bus.ex_redirect = 0;
        step();
        sample(); cmp("rd2_c4_iff", 32'(bus.if_id_flush), 1); advance();
        sample(); cmp("rd2_c5_iff", 32'(bus.if_id_flush), 0); advance();

        // Simultaneous: redirect wins over load-use and imem wait.
        load_use_on(5'd7); bus.imem_ready = 0; bus.ex_redirect = 1;
        sample(); cmp("sim_pc", 32'(bus.pc_en), 1); cmp("sim_stall", 32'(bus.if_id_stall), 0); advance();
        bus.ex_redirect = 0;
        step(); step();
        sample(); cmp("lu_imem_stall", 32'(bus.if_id_stall), 1); cmp("lu_imem_iff", 32'(bus.if_id_flush), 0);
        advance();
        idle();
        bus.imem_ready = 0;
        sample(); cmp("imem_iff", 32'(bus.if_id_flush), 1); cmp("imem_pc", 32'(bus.pc_en), 0); advance();
        idle();

        // Reset mid MC_WAIT aborts immediately.
        bus.ex_mc_start = 1; step();
        bus.ex_mc_start = 0; step();
        rst = 0;
        #1;
        cmp("rst_mid_stall", 32'(bus.if_id_stall), 0); cmp("rst_mid_hold", 32'(bus.ex_hold), 0);
        step();
        rst = 1;
        sample(); cmp("rst_rel_pc", 32'(bus.pc_en), 1); advance();

        // Counters: three stall cycles then two redirects.
        rst = 0; #1; step(); rst = 1;
        load_use_on(5'd3);
        step(); step(); step();
        idle();
        bus.ex_redirect = 1; step(); bus.ex_redirect = 0; step(); step();
        bus.ex_redirect = 1; step(); bus.ex_redirect = 0; step(); step();
        sample();
`ifdef PIPE_CTRL_PERF_EN
        cmp("perf_stalls", bus.stall_cycles, 32'd3);
        cmp("perf_flushes", bus.flush_count, 32'd2);
`else
        cmp("perf_stalls_off", bus.stall_cycles, 32'd0);
        cmp("perf_flushes_off", bus.flush_count, 32'd0);
`endif
        advance();

        // Random traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            rst             = ($urandom_range(0, 63) != 0);
            bus.id_valid    = ($urandom_range(0, 7) != 0);
            bus.id_rs1      = 5'($urandom_range(0, 7));
            bus.id_rs2      = 5'($urandom_range(0, 7));
            bus.id_uses_rs1 = 1'($urandom);
            bus.id_uses_rs2 = 1'($urandom);
            bus.ex_valid    = ($urandom_range(0, 7) != 0);
            bus.ex_is_load  = 1'($urandom);
            bus.ex_rd       = 5'($urandom_range(0, 7));
            bus.ex_redirect = ($urandom_range(0, 7) == 0);
            bus.ex_mc_start = ($urandom_range(0, 5) == 0);
            bus.mc_done     = ($urandom_range(0, 2) == 0);
            bus.imem_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
